// File: rtl/pi_pkg.sv
// Shared constants and packet-layout helpers for the pi-tree leaf client.
// A packet is {flag, addr, data}; the flag bit is always driven low by clients.
package pi_pkg;

  localparam int CNT_W = 16;

  function automatic int pkt_w(input int a_w, input int d_w);
    return a_w + d_w + 1;
  endfunction

  function automatic int addr_lsb(input int d_w);
    return d_w;
  endfunction

  function automatic int flag_bit(input int a_w, input int d_w);
    return a_w + d_w;
  endfunction

endpackage

// File: rtl/pi_fifo.sv
// Synchronous FIFO with registered count and full/empty flags.
// A pop on an empty FIFO is ignored, so a push into an empty FIFO is never bypassed.
module pi_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/pi_client.sv
// Leaf endpoint of the backpressured pi-tree NoC: buffered TX into a switch input,
// buffered RX from a switch output, plus transfer counters, misroute flag and idle.
module pi_client
  import pi_pkg::*;
#(
  parameter int N     = 4,
  parameter int A_W   = $clog2(N) + 1,
  parameter int D_W   = 32,
  parameter int posx  = 0,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [A_W-1:0]              tx_addr,
  input  logic [D_W-1:0]              tx_data,
  output logic [pkt_w(A_W, D_W)-1:0]  net_o,
  output logic                        net_o_v,
  input  logic                        net_o_bp,
  input  logic [pkt_w(A_W, D_W)-1:0]  net_i,
  input  logic                        net_i_v,
  output logic                        net_i_bp,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [A_W-1:0]              rx_addr,
  output logic [D_W-1:0]              rx_data,
  output logic [CNT_W-1:0]            tx_cnt,
  output logic [CNT_W-1:0]            rx_cnt,
  output logic                        misroute,
  output logic                        idle
);

  localparam int PKT_W    = pkt_w(A_W, D_W);
  localparam int ADDR_LSB = addr_lsb(D_W);
  localparam int FLAG_BIT = flag_bit(A_W, D_W);
  localparam int FIFO_W   = A_W + D_W;

  logic [PKT_W-1:0]  r_net_o;
  logic              r_net_o_v;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic              r_misroute;
  logic              r_idle;

  logic [FIFO_W-1:0] w_tx_head;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_tx_load;
  logic              w_tx_pop;
  logic              w_tx_xfer;

  logic [FIFO_W-1:0] w_rx_head;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic              w_rx_acc;
  logic [A_W-1:0]    w_rx_in_addr;
  logic              w_unused_flag;

  // ---------------------------------------------------------------- TX path
  pi_fifo #(
    .W     (FIFO_W),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (tx_valid),
    .i_data  ({tx_addr, tx_data}),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  // The output register refills whenever its word is leaving or it holds nothing,
  // which keeps a full-rate stream while the switch is not pushing back.
  assign w_tx_load = ~(r_net_o_v & net_o_bp);
  assign w_tx_pop  = w_tx_load & ~w_tx_empty;
  assign w_tx_xfer = r_net_o_v & ~net_o_bp;

  // ---------------------------------------------------------------- RX path
  assign w_rx_acc      = net_i_v & ~w_rx_full;
  assign w_rx_in_addr  = net_i[ADDR_LSB +: A_W];
  assign w_unused_flag = net_i[FLAG_BIT];

  pi_fifo #(
    .W     (FIFO_W),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_acc),
    .i_data  (net_i[FIFO_W-1:0]),
    .i_pop   (rx_ready),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // ------------------------------------------------- output register, stats
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_net_o    <= '0;
      r_net_o_v  <= 1'b0;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_misroute <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      if (w_tx_load) begin
        r_net_o_v <= ~w_tx_empty;
        if (!w_tx_empty) begin
          r_net_o <= {1'b0, w_tx_head};
        end
      end
      if (w_tx_xfer) begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
      if (w_rx_acc) begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
        if (w_rx_in_addr != A_W'(posx)) begin
          r_misroute <= 1'b1;
        end
      end
      r_idle <= w_tx_empty & w_rx_empty & ~r_net_o_v & ~net_i_v;
    end
  end

  assign tx_ready = ~w_tx_full;
  assign net_o    = r_net_o;
  assign net_o_v  = r_net_o_v;
  assign net_i_bp = w_rx_full;
  assign rx_valid = ~w_rx_empty;
  assign rx_addr  = w_rx_head[ADDR_LSB +: A_W];
  assign rx_data  = w_rx_head[D_W-1:0];
  assign tx_cnt   = r_tx_cnt;
  assign rx_cnt   = r_rx_cnt;
  assign misroute = r_misroute;
  assign idle     = r_idle;

endmodule

// File: doc/pi_client.md
Name: pi_client

Overview:
- Leaf endpoint of the backpressured pi-tree NoC. It is the far end of a switch's leaf link.
- TX side: buffers host packets and drives them into a switch input port, obeying that port's bp.
- RX side: accepts packets from a switch output port into a FIFO and drives bp back to the switch.
- Also provides transfer counters, a misroute sticky flag and an idle indicator.

Parameters:
- N, 4, number of clients in the tree.
- A_W, $clog2(N)+1, address field width.
- D_W, 32, data field width.
- posx, 0, this client's address; also the expected RX destination.
- DEPTH, 4, entries in each of the TX and RX FIFOs; power of two, >=2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- tx_valid  in  1  host offers a packet.
- tx_ready  out  1  TX FIFO not full.
- tx_addr  in  A_W  destination client.
- tx_data  in  D_W  payload.
- net_o  out  A_W+D_W+1  packet to switch input; {1'b0, addr, data}.
- net_o_v  out  1  net_o valid.
- net_o_bp  in  1  switch input backpressure.
- net_i  in  A_W+D_W+1  packet from switch output.
- net_i_v  in  1  net_i valid.
- net_i_bp  out  1  backpressure to switch.
- rx_valid  out  1  RX FIFO head valid.
- rx_ready  in  1  host pops the head.
- rx_addr  out  A_W  head address field.
- rx_data  out  D_W  head data field.
- tx_cnt  out  16  packets delivered to the network.
- rx_cnt  out  16  packets accepted from the network.
- misroute  out  1  sticky; an accepted packet had addr != posx.
- idle  out  1  both FIFOs empty, net_o_v low, net_i_v low.

Behaviour:
- Transfer rule on both network links: a word moves on a posedge where v=1 and bp=0. While bp=1, the sender holds word and v unchanged.
- Reset (rst==0 at posedge), regardless of traffic in flight:
  - FIFO pointers and counters cleared.
  - net_o_v=0, net_o=0, net_i_bp=0, misroute=0.
  - tx_ready=1, rx_valid=0, idle=1 on the next cycle.
  - Packets in flight are dropped.
- TX FIFO:
  - Write on tx_valid & tx_ready.
  - tx_ready = !full, decoded from registered count.
- TX output register (net_o, net_o_v):
  - Loads when !(net_o_v & net_o_bp).
  - If the FIFO is non-empty: load the head, pop it, net_o_v<=1.
  - Otherwise net_o_v<=0.
  - Gives back-to-back words at full rate when bp=0.
- TX latency: host write at edge t, net_o_v high after edge t+1, given an empty path and bp=0.
- tx_cnt increments on each net_o_v & !net_o_bp; wraps at 16'hFFFF.
- net_o[A_W+D_W] is always 0.
- RX accept: acc = net_i_v & !net_i_bp.
  - net_i_bp = (rx_count == DEPTH), decoded from registered count only; no combinational path from net_i_v.
  - On acc, write {addr, data} into the RX FIFO; bit A_W+D_W is ignored.
  - rx_cnt increments on acc; wraps.
- Simultaneous pop (rx_valid & rx_ready) and acc while full: not possible, because bp=1 blocks acc. bp deasserts the cycle after the pop.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.
- Simultaneous push and pop on an empty TX FIFO: push only; the head is not bypassed.
- rx_valid = !rx_empty. rx_addr/rx_data are the head fields, from registered storage.
- misroute sets on acc with net_i addr != posx. It clears only on reset.
- idle is registered, computed from the current-cycle terms.

Decomposition:
- Package pi_pkg holds:
  - width function pkt_w(A_W,D_W)=A_W+D_W+1;
  - field slice offsets ADDR_LSB=D_W and FLAG_BIT=A_W+D_W;
  - counter width CNT_W=16.
- Sub-module pi_fifo #(W, DEPTH): synchronous FIFO with registered count/full/empty and active-low sync reset. It is instantiated twice (TX, RX).
- Output register, counters and flags live in pi_client.

Test Plan:
- Reset mid-traffic: rst low one cycle with both FIFOs holding 2 entries -> next cycle net_o_v=0, rx_valid=0, tx_cnt=rx_cnt=0, tx_ready=1, idle=1.
- TX streaming: 4 packets addr=2, data=0xA0..0xA3, net_o_bp=0 -> net_o_v high from edge 2 for 4 consecutive cycles, data in order, tx_cnt=4.
- TX backpressure: net_o_bp=1 for 5 cycles while net_o holds 0xA1 -> net_o and net_o_v stable, tx_cnt frozen. Release -> 0xA1 sent once, then 0xA2.
- RX fill: DEPTH=4, rx_ready=0, network offers 6 words to posx=1 -> net_i_bp rises after 4 accepts, rx_cnt=4. Popping one -> bp falls next cycle and word 5 is accepted.
- Misroute: posx=1, accept a packet with addr=3 -> misroute=1 and stays 1 through later correct packets until reset.
- Counter wrap: preload traffic to 65535 transfers -> next transfer gives tx_cnt=0.
